// File: rtl/clkgen_sup_pkg.sv
// Shared types and constants for the clock-generator lock supervisor.
// Holds the state encoding, the lock/loss filter lengths and the saturating counter helpers.
package clkgen_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_LOCKED    = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam int unsigned LOCK_FILT_LEN = 16;
    localparam int unsigned LOSS_FILT_LEN = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'h1F) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk_i domain.
module sync2ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous level through two back-to-back flops
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/clkgen_lock_supervisor.sv
// Programs a clock manager (reset, load M/D, wait done, wait lock) with timeouts and retries.
// Optional LOCK_WATCHDOG_EN: re-program automatically when lock is lost for 8 cycles in LOCKED.
module clkgen_lock_supervisor
    import clkgen_sup_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned RESET_CYCLES   = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_i,
    input  logic [7:0] mul_i,
    input  logic [7:0] div_i,
    output logic       clkgen_reset_o,
    output logic       clkgen_load_o,
    output logic [7:0] clkgen_mul_o,
    output logic [7:0] clkgen_div_o,
    input  logic       clkgen_done_i,
    input  logic       locked_i,
    output logic       busy_o,
    output logic       ok_o,
    output logic       fail_o,
    output logic [2:0] retries_o
);

    localparam logic [2:0]  L_MAX_RETRY = 3'(MAX_RETRY);
    localparam logic [15:0] L_RST_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] L_TO_LAST   = TIMEOUT_CYCLES - 16'd1;
    localparam logic [4:0]  L_LOCK_LAST = 5'(LOCK_FILT_LEN - 1);
    localparam logic [4:0]  L_LOSS_LAST = 5'(LOSS_FILT_LEN - 1);

    logic        w_done_s;
    logic        w_locked_s;
    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_fail_nxt;
    logic        w_accept;
    logic        w_attempt_fail;
    logic        w_wd_trip;
    logic [15:0] r_cnt;
    logic [4:0]  r_flt_cnt;
    logic        r_done_d;
    logic [7:0]  r_mul;
    logic [7:0]  r_div;
    logic [2:0]  r_retries;
    logic        r_clkgen_reset;
    logic        r_clkgen_load;
    logic        r_busy;
    logic        r_ok;
    logic        r_fail;

    sync2ff u_sync_done (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (clkgen_done_i),
        .q_o     (w_done_s)
    );

    sync2ff u_sync_locked (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (locked_i),
        .q_o     (w_locked_s)
    );

    assign w_fail_nxt = (r_retries < L_MAX_RETRY) ? ST_RST : ST_FAIL;

    // Next-state decision; timeouts are lower priority than the event being waited for
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_attempt_fail = 1'b0;
        w_wd_trip      = 1'b0;
        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (req_i) begin
                    w_state_nxt = ST_RST;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOCKED: begin
                if (req_i) begin
                    w_state_nxt = ST_RST;
                    w_accept    = 1'b1;
                end
`ifdef LOCK_WATCHDOG_EN
                else if (!w_locked_s && (r_flt_cnt == L_LOSS_LAST)) begin
                    w_state_nxt = ST_RST;
                    w_wd_trip   = 1'b1;
                end
`endif
                else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RST: begin
                if (r_cnt == L_RST_LAST) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_RST;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_s && !r_done_d) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == L_TO_LAST) begin
                    w_attempt_fail = 1'b1;
                    w_state_nxt    = w_fail_nxt;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s && (r_flt_cnt == L_LOCK_LAST)) begin
                    w_state_nxt = ST_LOCKED;
                end else if (r_cnt == L_TO_LAST) begin
                    w_attempt_fail = 1'b1;
                    w_state_nxt    = w_fail_nxt;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched codes and status outputs registered from the next state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_flt_cnt      <= 5'd0;
            r_done_d       <= 1'b0;
            r_mul          <= 8'd0;
            r_div          <= 8'd0;
            r_retries      <= 3'd0;
            r_clkgen_reset <= 1'b1;
            r_clkgen_load  <= 1'b0;
            r_busy         <= 1'b0;
            r_ok           <= 1'b0;
            r_fail         <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_d <= w_done_s;

            if (w_state_nxt != r_state) begin
                r_cnt     <= 16'd0;
                r_flt_cnt <= 5'd0;
            end else begin
                r_cnt <= sat_inc16(r_cnt);
                // Consecutive-high run while waiting for lock, consecutive-low run once locked
                if (r_state == ST_WAIT_LOCK) begin
                    r_flt_cnt <= w_locked_s ? sat_inc5(r_flt_cnt) : 5'd0;
                end else if (r_state == ST_LOCKED) begin
                    r_flt_cnt <= w_locked_s ? 5'd0 : sat_inc5(r_flt_cnt);
                end else begin
                    r_flt_cnt <= 5'd0;
                end
            end

            if (w_accept) begin
                r_mul     <= mul_i;
                r_div     <= div_i;
                r_retries <= 3'd0;
            end else if (w_wd_trip) begin
                r_retries <= 3'd0;
            end else if (w_attempt_fail && (w_state_nxt == ST_RST)) begin
                r_retries <= r_retries + 3'd1;
            end else begin
                r_retries <= r_retries;
            end

            r_clkgen_reset <= (w_state_nxt == ST_RST);
            r_clkgen_load  <= (w_state_nxt == ST_LOAD);
            r_busy         <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_LOAD) ||
                              (w_state_nxt == ST_WAIT_DONE) || (w_state_nxt == ST_WAIT_LOCK);
            r_ok           <= (w_state_nxt == ST_LOCKED);
            r_fail         <= (w_state_nxt == ST_FAIL);
        end
    end

    assign clkgen_reset_o = r_clkgen_reset;
    assign clkgen_load_o  = r_clkgen_load;
    assign clkgen_mul_o   = r_mul;
    assign clkgen_div_o   = r_div;
    assign busy_o         = r_busy;
    assign ok_o           = r_ok;
    assign fail_o         = r_fail;
    assign retries_o      = r_retries;

endmodule

// File: tb/tb_clkgen_lock_supervisor.sv
// Scoreboard bench for clkgen_lock_supervisor: stimulus queues expected events, a monitor pops them.
module tb_clkgen_lock_supervisor;

    localparam int EV_RSTP = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_OK   = 2;
    localparam int EV_FAIL = 3;

    typedef struct {
        int         kind;
        logic [7:0] mul;
        logic [7:0] div;
        logic [2:0] ret;
        int         width;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       req_i = 1'b0;
    logic [7:0] mul_i = 8'd0;
    logic [7:0] div_i = 8'd0;
    logic       clkgen_done_i = 1'b0;
    logic       locked_i = 1'b0;
    logic       clkgen_reset_o;
    logic       clkgen_load_o;
    logic [7:0] clkgen_mul_o;
    logic [7:0] clkgen_div_o;
    logic       busy_o;
    logic       ok_o;
    logic       fail_o;
    logic [2:0] retries_o;

    always #5 clk = ~clk;

    clkgen_lock_supervisor #(
        .TIMEOUT_CYCLES (16'd100),
        .MAX_RETRY      (3),
        .RESET_CYCLES   (8)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .mul_i          (mul_i),
        .div_i          (div_i),
        .clkgen_reset_o (clkgen_reset_o),
        .clkgen_load_o  (clkgen_load_o),
        .clkgen_mul_o   (clkgen_mul_o),
        .clkgen_div_o   (clkgen_div_o),
        .clkgen_done_i  (clkgen_done_i),
        .locked_i       (locked_i),
        .busy_o         (busy_o),
        .ok_o           (ok_o),
        .fail_o         (fail_o),
        .retries_o      (retries_o)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input int k, input logic [7:0] m, input logic [7:0] d, input logic [2:0] r);
        ev_t e;
        e.kind  = k;
        e.mul   = m;
        e.div   = d;
        e.ret   = r;
        e.width = 8;
        exp_q.push_back(e);
    endtask

    task automatic push_attempt(input logic [7:0] m, input logic [7:0] d, input logic [2:0] r);
        push(EV_RSTP, 8'd0, 8'd0, 3'd0);
        push(EV_LOAD, m, d, r);
    endtask

    task automatic check_ev(input int k, input int w);
        ev_t e;
        logic ok;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ev_unexpected: got kind %0d expected no event", k);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == k);
            if (ok && k == EV_RSTP) ok = (w == e.width);
            if (ok && k == EV_LOAD) ok = (clkgen_mul_o == e.mul) && (clkgen_div_o == e.div) &&
                                         (retries_o == e.ret);
            if (ok && (k == EV_OK || k == EV_FAIL)) ok = (retries_o == e.ret);
            if (!ok) begin
                bad++;
                $display("FAIL ev_kind%0d: got kind=%0d w=%0d mul=%0h div=%0h ret=%0d expected kind=%0d w=%0d mul=%0h div=%0h ret=%0d",
                         e.kind, k, w, clkgen_mul_o, clkgen_div_o, retries_o,
                         e.kind, e.width, e.mul, e.div, e.ret);
            end
        end
    endtask

    // Monitor: reset-pulse widths, load pulses and rising status flags
    initial begin
        int   run;
        logic ok_prev;
        logic fail_prev;
        run = 0;
        ok_prev = 1'b0;
        fail_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                run = 0;
                ok_prev = 1'b0;
                fail_prev = 1'b0;
            end else begin
                if (clkgen_reset_o && busy_o) begin
                    run++;
                end else if (run != 0) begin
                    check_ev(EV_RSTP, run);
                    run = 0;
                end
                if (clkgen_load_o) check_ev(EV_LOAD, 0);
                if (ok_o && !ok_prev) check_ev(EV_OK, 0);
                if (fail_o && !fail_prev) check_ev(EV_FAIL, 0);
                ok_prev = ok_o;
                fail_prev = fail_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] m, input logic [7:0] d);
        tick();
        req_i = 1'b1;
        mul_i = m;
        div_i = d;
        tick();
        req_i = 1'b0;
    endtask

    // which: 0 ok_o, 1 fail_o, 2 busy_o, other clkgen_load_o
    task automatic wait_for(input int which, input int bound, input string nm);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = ok_o;
                1:       hit = fail_o;
                2:       hit = busy_o;
                default: hit = clkgen_load_o;
            endcase
        end
        chk(nm, 16'(hit), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic hit;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vals", {clkgen_reset_o, clkgen_load_o, busy_o, ok_o, fail_o, retries_o}, 16'h0080);
        chk("rst_md", {clkgen_mul_o, clkgen_div_o}, 16'h0000);
        tick();
        reset_i = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_rst_low", {clkgen_reset_o, busy_o}, 16'd0);

        // Clean lock on the first attempt
        push_attempt(8'h0A, 8'h04, 3'd0);
        push(EV_OK, 8'd0, 8'd0, 3'd0);
        do_req(8'h0A, 8'h04);
        repeat (18) tick();
        clkgen_done_i = 1'b1;
        locked_i = 1'b1;
        wait_for(0, 200, "s1_ok");
        chk("s1_retries", 16'(retries_o), 16'd0);

        // Done never arrives: four attempts then FAIL
        for (int r = 0; r < 4; r++) push_attempt(8'h33, 8'h05, 3'(r));
        push(EV_FAIL, 8'd0, 8'd0, 3'd3);
        do_req(8'h33, 8'h05);
        clkgen_done_i = 1'b0;
        locked_i = 1'b0;
        wait_for(1, 1000, "s2_fail");
        chk("s2_retries", 16'(retries_o), 16'd3);

        // Short lock bursts never qualify; first attempt times out
        push_attempt(8'h11, 8'h02, 3'd0);
        push_attempt(8'h11, 8'h02, 3'd1);
        push(EV_OK, 8'd0, 8'd0, 3'd1);
        do_req(8'h11, 8'h02);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            locked_i = ((i / 10) % 2) == 0;
            clkgen_done_i = (i >= 18) && (i < 40);
            if (clkgen_load_o && (retries_o == 3'd1)) hit = 1'b1;
        end
        chk("s3_retry_load", 16'(hit), 16'd1);
        locked_i = 1'b0;
        clkgen_done_i = 1'b0;

        // Request during WAIT_DONE is ignored
        repeat (5) tick();
        do_req(8'h20, 8'h09);
        repeat (2) tick();
        chk("s4_md_kept", {clkgen_mul_o, clkgen_div_o}, 16'h1102);
        chk("s4_busy", 16'(busy_o), 16'd1);
        clkgen_done_i = 1'b1;
        locked_i = 1'b1;
        wait_for(0, 300, "s4_ok");
        chk("s4_retries", 16'(retries_o), 16'd1);

`ifdef LOCK_WATCHDOG_EN
        // 7-cycle loss tolerated, 8-cycle loss re-programs the same codes
        locked_i = 1'b0;
        repeat (7) tick();
        locked_i = 1'b1;
        repeat (6) tick();
        chk("s5_short_drop", {busy_o, ok_o}, 16'h0001);
        push_attempt(8'h11, 8'h02, 3'd0);
        push(EV_OK, 8'd0, 8'd0, 3'd0);
        clkgen_done_i = 1'b0;
        locked_i = 1'b0;
        repeat (8) tick();
        locked_i = 1'b1;
        wait_for(2, 20, "s5_busy");
        repeat (20) tick();
        clkgen_done_i = 1'b1;
        wait_for(0, 300, "s5_ok");
`else
        // Without the watchdog, lock loss leaves LOCKED untouched
        locked_i = 1'b0;
        repeat (20) tick();
        chk("s5_ok_held", {busy_o, ok_o}, 16'h0001);
        locked_i = 1'b1;
`endif

        // Reset in the middle of WAIT_LOCK
        push_attempt(8'h44, 8'h06, 3'd0);
        do_req(8'h44, 8'h06);
        clkgen_done_i = 1'b0;
        locked_i = 1'b0;
        repeat (20) tick();
        clkgen_done_i = 1'b1;
        repeat (15) tick();
        chk("s6_busy", {busy_o, ok_o}, 16'h0002);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("s6_rst_vals", {clkgen_reset_o, clkgen_load_o, busy_o, ok_o, fail_o, retries_o}, 16'h0080);
        chk("s6_rst_md", {clkgen_mul_o, clkgen_div_o}, 16'h0000);
        @(negedge clk);
        chk("s6_idle", {clkgen_reset_o, busy_o, ok_o, fail_o}, 16'd0);

        repeat (5) tick();
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
